// File: rtl/ncl_fa_sync_bridge.sv
// Clocked bridge driving a dual-rail NCL full-adder stage through
// a four-phase DATA/NULL handshake with synchronized acknowledgements.
module ncl_fa_sync_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic       clk,
  input  logic       init_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_a,
  input  logic       in_b,
  input  logic       in_c,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sum,
  output logic       out_cout,
  output logic [1:0] A,
  output logic [1:0] B,
  output logic [1:0] carryin,
  input  logic       ABCOMP,
  input  logic       carryinCOMP,
  input  logic [1:0] sum,
  input  logic [1:0] carryout,
  output logic       sumCOMP,
  output logic       carryCOMP,
  output logic       err_timeout,
  output logic       err_illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_DDATA, S_DNULL, S_COLL, S_REL, S_HOLD
  } state_t;

  state_t r_state;
  logic [SYNC_STAGES-1:0][5:0] r_sync;
  logic [3:0]  r_prev;
  logic [1:0]  r_a, r_b, r_c;
  logic        r_comp, r_in_ready, r_out_valid;
  logic        r_osum, r_ocout, r_have;
  logic [15:0] r_wait;
  logic        r_err_to, r_err_il;

  logic [5:0] w_async, w_sy;
  logic       w_ab, w_ci;
  logic [1:0] w_sum, w_cy;
  logic       w_sum_st, w_cy_st;
  logic       w_res_data, w_res_null, w_illegal;
  logic       w_wait_st, w_early;

  assign w_async = {ABCOMP, carryinCOMP, sum, carryout};
  assign w_sy    = r_sync[SYNC_STAGES-1];
  assign w_ab    = w_sy[5];
  assign w_ci    = w_sy[4];
  assign w_sum   = w_sy[3:2];
  assign w_cy    = w_sy[1:0];

  // A pair is trusted only after two equal synchronized samples.
  assign w_sum_st   = (w_sum == r_prev[3:2]);
  assign w_cy_st    = (w_cy == r_prev[1:0]);
  assign w_res_data = w_sum_st && w_cy_st && (^w_sum) && (^w_cy);
  assign w_res_null = w_sum_st && w_cy_st
                      && (w_sum == 2'b00) && (w_cy == 2'b00);
  assign w_illegal  = (w_sum_st && (&w_sum)) || (w_cy_st && (&w_cy));

  assign w_wait_st = (r_state == S_DDATA) || (r_state == S_DNULL)
                     || (r_state == S_COLL) || (r_state == S_REL);
  assign w_early   = ((r_state == S_DDATA) || (r_state == S_DNULL))
                     && !r_have && w_res_data;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_async};
      r_prev <= w_sy[3:0];
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state     <= S_IDLE;
      r_a         <= 2'b00;
      r_b         <= 2'b00;
      r_c         <= 2'b00;
      r_comp      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_osum      <= 1'b0;
      r_ocout     <= 1'b0;
      r_have      <= 1'b0;
      r_wait      <= '0;
      r_err_to    <= 1'b0;
      r_err_il    <= 1'b0;
    end else begin
      if (w_illegal) r_err_il <= 1'b1;
      if (w_wait_st) begin
        if (r_wait != 16'hFFFF) r_wait <= r_wait + 16'd1;
        if (({1'b0, r_wait} + 17'd1) >= 17'(TIMEOUT))
          r_err_to <= 1'b1;
      end
      // Result may arrive before input NULL is acknowledged.
      if (w_early) begin
        r_osum  <= w_sum[1];
        r_ocout <= w_cy[1];
        r_have  <= 1'b1;
      end
      unique case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (in_valid && r_in_ready) begin
            r_a        <= {in_a, ~in_a};
            r_b        <= {in_b, ~in_b};
            r_c        <= {in_c, ~in_c};
            r_in_ready <= 1'b0;
            r_have     <= 1'b0;
            r_wait     <= '0;
            r_state    <= S_DDATA;
          end
        end
        S_DDATA: begin
          if (w_ab && w_ci) begin
            r_a     <= 2'b00;
            r_b     <= 2'b00;
            r_c     <= 2'b00;
            r_wait  <= '0;
            r_state <= S_DNULL;
          end
        end
        S_DNULL: begin
          if (!w_ab && !w_ci) begin
            r_wait <= '0;
            if (r_have || w_res_data) begin
              r_comp  <= 1'b1;
              r_state <= S_REL;
            end else begin
              r_state <= S_COLL;
            end
          end
        end
        S_COLL: begin
          if (w_res_data) begin
            r_osum  <= w_sum[1];
            r_ocout <= w_cy[1];
            r_have  <= 1'b1;
            r_comp  <= 1'b1;
            r_wait  <= '0;
            r_state <= S_REL;
          end
        end
        S_REL: begin
          if (w_res_null) begin
            r_comp      <= 1'b0;
            r_out_valid <= 1'b1;
            r_wait      <= '0;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign A           = r_a;
  assign B           = r_b;
  assign carryin     = r_c;
  assign sumCOMP     = r_comp;
  assign carryCOMP   = r_comp;
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_sum     = r_osum;
  assign out_cout    = r_ocout;
  assign err_timeout = r_err_to;
  assign err_illegal = r_err_il;

endmodule

// File: tb/tb_ncl_fa_sync_bridge.sv
// Directed bench for ncl_fa_sync_bridge with a zero-delay NCL adder
// model whose outputs only go NULL once the bridge acknowledges.
module tb_ncl_fa_sync_bridge;

  logic       clk = 1'b0;
  logic       init_n;
  logic       in_valid, in_ready;
  logic       in_a, in_b, in_c;
  logic       out_valid, out_ready;
  logic       out_sum, out_cout;
  logic [1:0] A, B, carryin;
  logic       ABCOMP, carryinCOMP;
  logic [1:0] sum, carryout;
  logic       sumCOMP, carryCOMP;
  logic       err_timeout, err_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  logic ab_en  = 1'b1;
  logic ill_en = 1'b0;
  logic m_hold = 1'b0;
  logic m_s    = 1'b0;
  logic m_c    = 1'b0;
  logic in_data, in_null;

  always #5 clk = ~clk;

  ncl_fa_sync_bridge #(.SYNC_STAGES(2), .TIMEOUT(10)) dut (
    .clk(clk), .init_n(init_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout),
    .A(A), .B(B), .carryin(carryin),
    .ABCOMP(ABCOMP), .carryinCOMP(carryinCOMP),
    .sum(sum), .carryout(carryout),
    .sumCOMP(sumCOMP), .carryCOMP(carryCOMP),
    .err_timeout(err_timeout), .err_illegal(err_illegal)
  );

  assign in_data = (^A) && (^B) && (^carryin);
  assign in_null = (A == 2'b00) && (B == 2'b00) && (carryin == 2'b00);

  always @(A or B or carryin or sumCOMP or init_n) begin
    if (!init_n) begin
      m_hold = 1'b0;
    end else if (in_data && !sumCOMP) begin
      m_hold = 1'b1;
      m_s = A[1] ^ B[1] ^ carryin[1];
      m_c = (A[1] & B[1]) | (A[1] & carryin[1]) | (B[1] & carryin[1]);
    end else if (in_null && sumCOMP) begin
      m_hold = 1'b0;
    end
  end

  assign ABCOMP      = ab_en && in_data;
  assign carryinCOMP = (carryin != 2'b00);
  assign sum      = ill_en ? 2'b11 : (m_hold ? {m_s, ~m_s} : 2'b00);
  assign carryout = m_hold ? {m_c, ~m_c} : 2'b00;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 20) begin
      step();
      k++;
    end
    chk("in_ready_wait", {15'd0, in_ready}, 16'd1);
  endtask

  task automatic send(input logic a, input logic b, input logic c);
    wait_ready();
    in_a = a;
    in_b = b;
    in_c = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int n0, output int n);
    n = n0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk(tag, {2'b00, in_ready, out_valid, out_sum, out_cout, A, B,
              carryin, sumCOMP, carryCOMP, err_timeout, err_illegal},
        16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [2:0] v;
    logic es, ec;
    init_n = 1'b0;
    in_valid = 1'b0;
    in_a = 1'b0;
    in_b = 1'b0;
    in_c = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk_reset_outs("reset_state");
    @(negedge clk);
    init_n = 1'b1;
    step();
    chk("in_ready_after_reset", {15'd0, in_ready}, 16'd1);

    // 1+1+1: rails, NULL phase, result and minimum latency
    send(1'b1, 1'b1, 1'b1);
    chk("rails_data_111", {10'd0, A, B, carryin}, 16'b101010);
    chk("in_ready_busy", {15'd0, in_ready}, 16'd0);
    step();
    step();
    step();
    chk("rails_null_111", {10'd0, A, B, carryin}, 16'd0);
    wait_valid(3, lat);
    chk("latency_111", lat[15:0], 16'd10);
    chk("result_111", {14'd0, out_sum, out_cout}, 16'b11);

    // consumer stalls in HOLD
    for (int i = 0; i < 20; i++) begin
      chk("hold_stable", {12'd0, out_valid, out_sum, out_cout, in_ready},
          16'b1110);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("hold_release", {14'd0, out_valid, in_ready}, 16'b01);

    // all operand combinations back to back
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      es = v[2] ^ v[1] ^ v[0];
      ec = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
      send(v[2], v[1], v[0]);
      wait_valid(0, lat);
      chk($sformatf("latency_%0d", i), lat[15:0], 16'd10);
      chk($sformatf("result_%0d", i), {14'd0, out_sum, out_cout},
          {14'd0, es, ec});
    end
    step();
    chk("no_errors", {14'd0, err_timeout, err_illegal}, 16'd0);

    // adder never acknowledges: timeout after 10 cycles of DRIVE_DATA
    ab_en = 1'b0;
    send(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step();
    chk("timeout_not_yet", {15'd0, err_timeout}, 16'd0);
    step();
    chk("timeout_set", {15'd0, err_timeout}, 16'd1);
    chk("timeout_rails", {10'd0, A, B, carryin}, 16'b100110);
    for (int i = 0; i < 5; i++) step();
    chk("timeout_sticky", {15'd0, err_timeout}, 16'd1);
    chk("timeout_rails_held", {10'd0, A, B, carryin}, 16'b100110);
    @(negedge clk);
    init_n = 1'b0;
    #1;
    chk_reset_outs("reset_async_timeout");
    ab_en = 1'b1;
    @(negedge clk);
    init_n = 1'b1;
    step();
    chk("in_ready_after_reset2", {15'd0, in_ready}, 16'd1);

    // illegal 11 on sum for 3 cycles while idle
    ill_en = 1'b1;
    step();
    step();
    step();
    ill_en = 1'b0;
    step();
    step();
    chk("illegal_set", {15'd0, err_illegal}, 16'd1);
    chk("illegal_no_result", {15'd0, out_valid}, 16'd0);
    for (int i = 0; i < 5; i++) step();
    chk("illegal_sticky", {15'd0, err_illegal}, 16'd1);
    @(negedge clk);
    init_n = 1'b0;
    #1;
    chk_reset_outs("reset_async_illegal");
    @(negedge clk);
    init_n = 1'b1;
    step();

    // reset while in RELEASE discards the token
    send(1'b0, 1'b1, 1'b1);
    lat = 0;
    while (!sumCOMP && lat < 20) begin
      step();
      lat++;
    end
    chk("release_reached", {15'd0, sumCOMP}, 16'd1);
    #2;
    init_n = 1'b0;
    #1;
    chk_reset_outs("reset_in_release");
    @(negedge clk);
    init_n = 1'b1;
    step();
    chk("in_ready_after_release_reset", {15'd0, in_ready}, 16'd1);
    for (int i = 0; i < 12; i++) step();
    chk("no_stale_action", {9'd0, out_valid, A, B, carryin, sumCOMP},
        16'd0);

    // bridge still works afterwards
    send(1'b0, 1'b1, 1'b0);
    wait_valid(0, lat);
    chk("latency_post", lat[15:0], 16'd10);
    chk("result_post", {14'd0, out_sum, out_cout}, 16'b10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
